sctag_iqbuf: RTL and testbench

SCTAG_IQBUF -- requirements
Module: sctag_iqbuf

---
 rtl/sctag_iq_pkg.sv | 20 ++
 rtl/sctag_iq_decode.sv | 18 +
 rtl/sctag_iqbuf.sv | 78 +++++++
 tb/tb_sctag_iqbuf.sv | 212 +++++++++++++++++++++
 4 files changed

// File: rtl/sctag_iq_pkg.sv
// PCX packet field positions and request-type codes shared by SCTAG blocks.
package sctag_iq_pkg;
  localparam int PCX_W        = 125;
  localparam int PCX_ATM      = 124;
  localparam int PCX_VBIT     = 123;
  localparam int PCX_RQTYP_HI = 122;
  localparam int PCX_RQTYP_LO = 118;
  localparam int PCX_NC       = 117;
  localparam int PCX_ADDR_HI  = 103;
  localparam int PCX_ADDR_LO  = 64;
  localparam int PCX_DATA_HI  = 63;
  localparam int PCX_DATA_LO  = 0;

  localparam logic [4:0] RQ_STORE   = 5'b00001;
  localparam logic [4:0] RQ_FWD_REQ = 5'b01101;

  // CSR space: addr[39:37]==3'b101 with addr[35] set
  localparam logic [2:0] CSR_SPACE = 3'b101;
  localparam int         CSR_BIT   = PCX_ADDR_LO + 35;
endpackage

// File: rtl/sctag_iq_decode.sv
// Combinational head-packet decode (atomic / CSR / store); outputs forced low when not valid.
module sctag_iq_decode
  import sctag_iq_pkg::*;
(
  input  logic             vld,
  input  logic [PCX_W-1:0] pkt,
  output logic             atm,
  output logic             csr,
  output logic             st
);
  logic [4:0] rqtyp;

  assign rqtyp = pkt[PCX_RQTYP_HI:PCX_RQTYP_LO];
  assign atm   = vld & pkt[PCX_ATM];
  assign csr   = vld & (pkt[PCX_ADDR_LO+39:PCX_ADDR_LO+37] == CSR_SPACE) & pkt[CSR_BIT];
  // forwarded requests count as stores only when the NC bit is clear
  assign st    = vld & ((rqtyp == RQ_STORE) | ((rqtyp == RQ_FWD_REQ) & ~pkt[PCX_NC]));
endmodule

// File: rtl/sctag_iqbuf.sv
// SCTAG input queue: circular FIFO of PCX packets with optional empty-queue bypass to the arbiter.
module sctag_iqbuf
  import sctag_iq_pkg::*;
#(
  parameter int DEPTH     = 16,
  parameter int DW        = 125,
  parameter int AF_MARGIN = 2,
  parameter int BYPASS_EN = 1
) (
  input  logic                       rclk,
  input  logic                       arst,
  input  logic                       pcx_vld_px2,
  input  logic [DW-1:0]              pcx_data_px2,
  input  logic                       arb_rdy_px2,
  output logic                       iq_vld_px2,
  output logic [DW-1:0]              iq_data_px2,
  output logic                       iq_atm_px2,
  output logic                       iq_csr_px2,
  output logic                       iq_st_px2,
  output logic [$clog2(DEPTH+1)-1:0] iq_cnt,
  output logic                       iq_afull,
  output logic                       iq_ovf_err
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);
  localparam logic [CW-1:0] AF_TH    = CW'(DEPTH - AF_MARGIN);
  localparam logic          BYP      = (BYPASS_EN != 0);

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr, rd_ptr;
  logic          empty, full, pop, pop_st, bypass, wr, drop;

  assign empty = (iq_cnt == '0);
  assign full  = (iq_cnt == CNT_FULL);

  // reset gating keeps a live pcx packet from bypassing while arst is held
  assign iq_vld_px2  = ~arst & (~empty | (BYP & pcx_vld_px2));
  assign iq_data_px2 = ~empty ? mem[rd_ptr] : (BYP ? pcx_data_px2 : '0);
  assign iq_afull    = ~arst & (iq_cnt >= AF_TH);

  assign pop    = iq_vld_px2 & arb_rdy_px2;
  assign pop_st = pop & ~empty;
  assign bypass = pop & empty;
  assign wr     = pcx_vld_px2 & ~bypass & (~full | pop_st);
  assign drop   = pcx_vld_px2 & full & ~pop_st;

  sctag_iq_decode u_dec (
    .vld (iq_vld_px2),
    .pkt (iq_data_px2[PCX_W-1:0]),
    .atm (iq_atm_px2),
    .csr (iq_csr_px2),
    .st  (iq_st_px2)
  );

  // storage is not reset; only pointers/count qualify its contents
  always_ff @(posedge rclk) begin
    if (wr) mem[wr_ptr] <= pcx_data_px2;
  end

  always_ff @(posedge rclk or posedge arst) begin
    if (arst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      iq_cnt     <= '0;
      iq_ovf_err <= 1'b0;
    end else begin
      if (wr)     wr_ptr <= wr_ptr + PW'(1);
      if (pop_st) rd_ptr <= rd_ptr + PW'(1);
      case ({wr, pop_st})
        2'b10:   iq_cnt <= iq_cnt + CW'(1);
        2'b01:   iq_cnt <= iq_cnt - CW'(1);
        default: iq_cnt <= iq_cnt;
      endcase
      if (drop) iq_ovf_err <= 1'b1;
    end
  end
endmodule

// File: tb/tb_sctag_iqbuf.sv
// Directed bench for sctag_iqbuf at DEPTH=4, AF_MARGIN=2, bypass enabled.
module tb_sctag_iqbuf;
  localparam int DEPTH = 4;
  localparam int DW    = 125;
  localparam int AFM   = 2;
  localparam int CW    = $clog2(DEPTH+1);

  logic          rclk = 1'b0;
  logic          arst;
  logic          pcx_vld_px2;
  logic [DW-1:0] pcx_data_px2;
  logic          arb_rdy_px2;
  logic          iq_vld_px2;
  logic [DW-1:0] iq_data_px2;
  logic          iq_atm_px2, iq_csr_px2, iq_st_px2;
  logic [CW-1:0] iq_cnt;
  logic          iq_afull, iq_ovf_err;

  int n_tot = 0;
  int n_bad = 0;

  always #5 rclk = ~rclk;

  sctag_iqbuf #(.DEPTH(DEPTH), .DW(DW), .AF_MARGIN(AFM), .BYPASS_EN(1)) dut (
    .rclk(rclk), .arst(arst),
    .pcx_vld_px2(pcx_vld_px2), .pcx_data_px2(pcx_data_px2), .arb_rdy_px2(arb_rdy_px2),
    .iq_vld_px2(iq_vld_px2), .iq_data_px2(iq_data_px2),
    .iq_atm_px2(iq_atm_px2), .iq_csr_px2(iq_csr_px2), .iq_st_px2(iq_st_px2),
    .iq_cnt(iq_cnt), .iq_afull(iq_afull), .iq_ovf_err(iq_ovf_err)
  );

  function automatic logic [DW-1:0] mk(input logic [4:0] rq, input logic nc,
                                       input logic [39:0] addr, input logic [63:0] d);
    logic [DW-1:0] p;
    p = '0;
    p[123] = 1'b1;
    p[122:118] = rq;
    p[117] = nc;
    p[103:64] = addr;
    p[63:0] = d;
    return p;
  endfunction

  task automatic step;
    @(posedge rclk); #1;
  endtask

  task automatic test_reset;
    arst = 1'b1; arb_rdy_px2 = 1'b1; pcx_vld_px2 = 1'b1;
    pcx_data_px2 = mk(5'b00001, 1'b0, 40'h0, 64'h11);
    #2;
    n_tot++; if (iq_vld_px2 !== 1'b0) begin n_bad++; $display("FAIL rst_vld got=%0b exp=0", iq_vld_px2); end
    n_tot++; if (iq_cnt !== '0) begin n_bad++; $display("FAIL rst_cnt got=%0d exp=0", iq_cnt); end
    n_tot++; if (iq_afull !== 1'b0) begin n_bad++; $display("FAIL rst_afull got=%0b exp=0", iq_afull); end
    n_tot++; if (iq_st_px2 !== 1'b0) begin n_bad++; $display("FAIL rst_st got=%0b exp=0", iq_st_px2); end
    n_tot++; if (iq_ovf_err !== 1'b0) begin n_bad++; $display("FAIL rst_ovf got=%0b exp=0", iq_ovf_err); end
    step;
    arst = 1'b0; pcx_vld_px2 = 1'b0; arb_rdy_px2 = 1'b0;
    step;
  endtask

  task automatic test_bypass;
    logic [DW-1:0] p;
    p = mk(5'b00001, 1'b0, 40'h0, 64'hB0);
    pcx_vld_px2 = 1'b1; pcx_data_px2 = p; arb_rdy_px2 = 1'b1;
    #1;
    n_tot++; if (iq_vld_px2 !== 1'b1) begin n_bad++; $display("FAIL byp_vld got=%0b exp=1", iq_vld_px2); end
    n_tot++; if (iq_st_px2 !== 1'b1) begin n_bad++; $display("FAIL byp_st got=%0b exp=1", iq_st_px2); end
    n_tot++; if (iq_data_px2 !== p) begin n_bad++; $display("FAIL byp_data got=%0h exp=%0h", iq_data_px2, p); end
    step;
    n_tot++; if (iq_cnt !== '0) begin n_bad++; $display("FAIL byp_cnt got=%0d exp=0", iq_cnt); end
    pcx_vld_px2 = 1'b0; arb_rdy_px2 = 1'b0;
    step;
  endtask

  task automatic test_fill_drain;
    logic [DW-1:0] e;
    arb_rdy_px2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pcx_vld_px2 = 1'b1; pcx_data_px2 = mk(5'b00010, 1'b0, 40'h0, 64'hA0 + 64'(i));
      step;
      n_tot++; if (iq_cnt !== CW'(i+1)) begin n_bad++; $display("FAIL fill_cnt%0d got=%0d exp=%0d", i, iq_cnt, i+1); end
      n_tot++; if (iq_afull !== (i+1 >= 2)) begin n_bad++; $display("FAIL fill_afull%0d got=%0b exp=%0b", i, iq_afull, (i+1 >= 2)); end
    end
    pcx_vld_px2 = 1'b1; pcx_data_px2 = mk(5'b00010, 1'b0, 40'h0, 64'hE0);
    #1;
    n_tot++; if (iq_ovf_err !== 1'b0) begin n_bad++; $display("FAIL ovf_pre got=%0b exp=0", iq_ovf_err); end
    step;
    n_tot++; if (iq_cnt !== CW'(4)) begin n_bad++; $display("FAIL ovf_cnt got=%0d exp=4", iq_cnt); end
    n_tot++; if (iq_ovf_err !== 1'b1) begin n_bad++; $display("FAIL ovf_set got=%0b exp=1", iq_ovf_err); end
    pcx_vld_px2 = 1'b0; arb_rdy_px2 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      e = mk(5'b00010, 1'b0, 40'h0, 64'hA0 + 64'(i));
      #1;
      n_tot++; if (iq_data_px2 !== e) begin n_bad++; $display("FAIL drain%0d got=%0h exp=%0h", i, iq_data_px2[63:0], e[63:0]); end
      step;
    end
    n_tot++; if (iq_cnt !== '0) begin n_bad++; $display("FAIL drain_cnt got=%0d exp=0", iq_cnt); end
    n_tot++; if (iq_vld_px2 !== 1'b0) begin n_bad++; $display("FAIL drain_vld got=%0b exp=0", iq_vld_px2); end
    n_tot++; if (iq_ovf_err !== 1'b1) begin n_bad++; $display("FAIL ovf_sticky got=%0b exp=1", iq_ovf_err); end
    arb_rdy_px2 = 1'b0;
  endtask

  task automatic test_wrap;
    logic [63:0] q[$];
    logic [63:0] h;
    logic [DW-1:0] e;
    arb_rdy_px2 = 1'b0;
    for (int i = 0; i < 4; i++) begin
      pcx_vld_px2 = 1'b1; pcx_data_px2 = mk(5'b00100, 1'b0, 40'h0, 64'h100 + 64'(i));
      q.push_back(64'h100 + 64'(i));
      step;
    end
    arb_rdy_px2 = 1'b1;
    for (int k = 0; k < 11; k++) begin
      pcx_vld_px2 = 1'b1; pcx_data_px2 = mk(5'b00100, 1'b0, 40'h0, 64'h104 + 64'(k));
      h = q.pop_front();
      q.push_back(64'h104 + 64'(k));
      e = mk(5'b00100, 1'b0, 40'h0, h);
      #1;
      n_tot++; if (iq_data_px2 !== e) begin n_bad++; $display("FAIL wrap_head%0d got=%0h exp=%0h", k, iq_data_px2[63:0], h); end
      step;
      n_tot++; if (iq_cnt !== CW'(4)) begin n_bad++; $display("FAIL wrap_cnt%0d got=%0d exp=4", k, iq_cnt); end
    end
    pcx_vld_px2 = 1'b0;
    while (q.size() > 0) begin
      h = q.pop_front();
      e = mk(5'b00100, 1'b0, 40'h0, h);
      #1;
      n_tot++; if (iq_data_px2 !== e) begin n_bad++; $display("FAIL wrap_drain got=%0h exp=%0h", iq_data_px2[63:0], h); end
      step;
    end
    n_tot++; if (iq_cnt !== '0) begin n_bad++; $display("FAIL wrap_end_cnt got=%0d exp=0", iq_cnt); end
    arb_rdy_px2 = 1'b0;
  endtask

  task automatic test_decode;
    logic [DW-1:0] pk [6];
    logic [2:0]    ex [6];   // {atm, csr, st}
    pk[0] = mk(5'b00100, 1'b0, 40'hA8_0000_0000, 64'h1); ex[0] = 3'b010;
    pk[1] = mk(5'b00100, 1'b0, 40'hA0_0000_0000, 64'h2); ex[1] = 3'b000;
    pk[2] = mk(5'b01101, 1'b1, 40'h0, 64'h3);            ex[2] = 3'b000;
    pk[3] = mk(5'b01101, 1'b0, 40'h0, 64'h4);            ex[3] = 3'b001;
    pk[4] = mk(5'b00001, 1'b0, 40'hA8_0000_0000, 64'h5); pk[4][124] = 1'b1; ex[4] = 3'b111;
    pk[5] = mk(5'b00110, 1'b0, 40'h0, 64'h6);            pk[5][124] = 1'b1; ex[5] = 3'b100;
    arb_rdy_px2 = 1'b1;
    for (int i = 0; i < 6; i++) begin
      pcx_vld_px2 = 1'b1; pcx_data_px2 = pk[i];
      #1;
      n_tot++; if ({iq_atm_px2, iq_csr_px2, iq_st_px2} !== ex[i]) begin n_bad++;
        $display("FAIL dec_byp%0d got=%b exp=%b", i, {iq_atm_px2, iq_csr_px2, iq_st_px2}, ex[i]); end
      step;
    end
    // same decode from stored head
    arb_rdy_px2 = 1'b0; pcx_vld_px2 = 1'b1; pcx_data_px2 = pk[4];
    step;
    pcx_vld_px2 = 1'b0;
    #1;
    n_tot++; if ({iq_atm_px2, iq_csr_px2, iq_st_px2} !== 3'b111) begin n_bad++;
      $display("FAIL dec_stored got=%b exp=111", {iq_atm_px2, iq_csr_px2, iq_st_px2}); end
    arb_rdy_px2 = 1'b1;
    step;
    // idle with decode-active bits on the bus: outputs must stay low
    pcx_vld_px2 = 1'b0; pcx_data_px2 = pk[4];
    #1;
    n_tot++; if ({iq_atm_px2, iq_csr_px2, iq_st_px2} !== 3'b000) begin n_bad++;
      $display("FAIL dec_idle got=%b exp=000", {iq_atm_px2, iq_csr_px2, iq_st_px2}); end
    arb_rdy_px2 = 1'b0;
    step;
  endtask

  task automatic test_reset_mid;
    logic [DW-1:0] p;
    arb_rdy_px2 = 1'b0;
    for (int i = 0; i < 3; i++) begin
      pcx_vld_px2 = 1'b1; pcx_data_px2 = mk(5'b00010, 1'b0, 40'h0, 64'h300 + 64'(i));
      step;
    end
    n_tot++; if (iq_cnt !== CW'(3)) begin n_bad++; $display("FAIL rm_cnt3 got=%0d exp=3", iq_cnt); end
    pcx_data_px2 = mk(5'b00010, 1'b0, 40'h0, 64'h303);
    #2;
    arst = 1'b1;
    #1;
    n_tot++; if (iq_vld_px2 !== 1'b0) begin n_bad++; $display("FAIL rm_vld got=%0b exp=0", iq_vld_px2); end
    n_tot++; if (iq_cnt !== '0) begin n_bad++; $display("FAIL rm_cnt got=%0d exp=0", iq_cnt); end
    n_tot++; if (iq_ovf_err !== 1'b0) begin n_bad++; $display("FAIL rm_ovf got=%0b exp=0", iq_ovf_err); end
    n_tot++; if (iq_afull !== 1'b0) begin n_bad++; $display("FAIL rm_afull got=%0b exp=0", iq_afull); end
    step;
    arst = 1'b0; pcx_vld_px2 = 1'b0;
    step;
    p = mk(5'b00001, 1'b0, 40'h0, 64'h3F0);
    pcx_vld_px2 = 1'b1; pcx_data_px2 = p; arb_rdy_px2 = 1'b1;
    #1;
    n_tot++; if (iq_data_px2 !== p || iq_vld_px2 !== 1'b1) begin n_bad++;
      $display("FAIL rm_byp got=%0h/%0b exp=%0h/1", iq_data_px2[63:0], iq_vld_px2, p[63:0]); end
    step;
    n_tot++; if (iq_cnt !== '0) begin n_bad++; $display("FAIL rm_byp_cnt got=%0d exp=0", iq_cnt); end
    pcx_vld_px2 = 1'b0; arb_rdy_px2 = 1'b0;
  endtask

  initial begin
    arst = 1'b1; pcx_vld_px2 = 1'b0; pcx_data_px2 = '0; arb_rdy_px2 = 1'b0;
    test_reset;
    test_bypass;
    test_fill_drain;
    test_wrap;
    test_decode;
    test_reset_mid;
    $display("test done: total=%0d bad=%0d", n_tot, n_bad);
    $finish;
  end
endmodule
